// File: rtl/cpu_step_clock.sv
// Clock-enable generator for the 6502 core: debounced step/mode keys, manual/auto run.
// Optional `CPU_STEP_CYCLE_COUNT_EN adds cycle_count (issued pulses) and its count_clr input.
module cpu_step_clock #(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned AUTO_DIV_W      = 18
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        key_step_n,
    input  logic        key_mode_n,
    input  logic        hold,
`ifdef CPU_STEP_CYCLE_COUNT_EN
    input  logic        count_clr,
    output logic [31:0] cycle_count,
`endif
    output logic        cpu_clk_en,
    output logic        manual,
    output logic        step_pressed
);

    localparam int unsigned NumKeys = 2;
    localparam int unsigned KeyStep = 0;
    localparam int unsigned KeyMode = 1;
    localparam int unsigned CntW    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [0:0] {
        StManual,
        StAuto
    } state_e;

    logic [NumKeys-1:0]                  raw_n;
    logic [NumKeys-1:0][SYNC_STAGES-1:0] sync_q, sync_d;
    logic [NumKeys-1:0][CntW-1:0]        cnt_q, cnt_d;
    logic [NumKeys-1:0]                  lvl_q, lvl_d;
    logic [NumKeys-1:0]                  evt_q, evt_d;

    state_e                state_q, state_d;
    logic [AUTO_DIV_W-1:0] div_q, div_d;
    logic                  cpu_clk_en_q, cpu_clk_en_d;
    logic                  manual_q, manual_d;

    assign raw_n = {key_mode_n, key_step_n};

    // Accepted levels are stored active-high (1 = pressed); synchronizers hold raw pin polarity.
    always_comb begin
        sync_d = sync_q;
        cnt_d  = cnt_q;
        lvl_d  = lvl_q;
        evt_d  = '0;
        for (int k = 0; k < NumKeys; k++) begin
            sync_d[k] = {sync_q[k][SYNC_STAGES-2:0], raw_n[k]};
            if (!sync_q[k][SYNC_STAGES-1] == lvl_q[k]) begin
                cnt_d[k] = '0;
            end else if (cnt_q[k] == CntLast) begin
                cnt_d[k] = '0;
                lvl_d[k] = ~lvl_q[k];
                evt_d[k] = ~lvl_q[k];
            end else begin
                cnt_d[k] = cnt_q[k] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '1;
            cnt_q  <= '0;
            lvl_q  <= '0;
            evt_q  <= '0;
        end else begin
            sync_q <= sync_d;
            cnt_q  <= cnt_d;
            lvl_q  <= lvl_d;
            evt_q  <= evt_d;
        end
    end

    // A mode event always takes priority over a step event or a divider wrap in the same cycle.
    always_comb begin
        state_d      = state_q;
        div_d        = div_q;
        cpu_clk_en_d = 1'b0;
        unique case (state_q)
            StManual: begin
                if (evt_q[KeyMode]) begin
                    state_d = StAuto;
                    div_d   = '0;
                end else if (evt_q[KeyStep] && !hold) begin
                    cpu_clk_en_d = 1'b1;
                end
            end
            StAuto: begin
                if (evt_q[KeyMode]) begin
                    state_d = StManual;
                    div_d   = '0;
                end else if (!hold) begin
                    div_d        = div_q + 1'b1;
                    cpu_clk_en_d = &div_q;
                end
            end
            default: begin
                state_d = StManual;
                div_d   = '0;
            end
        endcase
        manual_d = (state_d == StManual);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StManual;
            div_q        <= '0;
            cpu_clk_en_q <= 1'b0;
            manual_q     <= 1'b1;
        end else begin
            state_q      <= state_d;
            div_q        <= div_d;
            cpu_clk_en_q <= cpu_clk_en_d;
            manual_q     <= manual_d;
        end
    end

    assign cpu_clk_en   = cpu_clk_en_q;
    assign manual       = manual_q;
    assign step_pressed = lvl_q[KeyStep];

`ifdef CPU_STEP_CYCLE_COUNT_EN
    logic [31:0] cycle_count_q, cycle_count_d;

    always_comb begin
        cycle_count_d = cycle_count_q;
        if (count_clr) begin
            cycle_count_d = '0;
        end else if (cpu_clk_en_q) begin
            cycle_count_d = cycle_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_count_q <= '0;
        end else begin
            cycle_count_q <= cycle_count_d;
        end
    end

    assign cycle_count = cycle_count_q;
`endif

endmodule
